// File: rtl/link_handshake.sv
// Board-to-board link bring-up and supervision: RDY / RDY_ACK / START / START_ACK handshake
// with bounded retry, then heartbeat keep-alive and loss detection while connected.
module link_handshake #(
    parameter int              DW             = 8,
    parameter int              TIMEOUT        = 10_000_000,
    parameter int              MAX_RETRY      = 7,
    parameter int              HB_PERIOD      = 5_000_000,
    parameter int              LOSS_TIMEOUT   = 20_000_000,
    parameter logic [DW-1:0]   CODE_RDY       = DW'('h90),
    parameter logic [DW-1:0]   CODE_RDY_ACK   = DW'('h91),
    parameter logic [DW-1:0]   CODE_START     = DW'('h92),
    parameter logic [DW-1:0]   CODE_START_ACK = DW'('h93),
    parameter logic [DW-1:0]   CODE_HB        = DW'('h94)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    input  logic          tx_busy,
    output logic [DW-1:0] tx_data,
    output logic          tx_send,
    output logic          link_up,
    output logic          initiator,
    output logic          link_lost,
    output logic          failed
);

    localparam int MAX_AB  = (TIMEOUT > HB_PERIOD) ? TIMEOUT : HB_PERIOD;
    localparam int MAX_CNT = (MAX_AB > LOSS_TIMEOUT) ? MAX_AB : LOSS_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT) + 1;
    localparam int RW      = $clog2(MAX_RETRY + 2);

    localparam logic [CW-1:0] WAIT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HB_LAST     = CW'(HB_PERIOD - 1);
    localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_INVITE, S_INV_WAIT, S_INV_ACK, S_INV_ACK_WAIT, S_STARTG,
        S_STARTG_WAIT, S_STARTG_ACK, S_CONNECTED, S_HB_SEND, S_FAILED
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] wait_reg, wait_next;
    logic [CW-1:0] hb_reg, hb_next;
    logic [CW-1:0] loss_reg, loss_next;
    logic [RW-1:0] retry_reg, retry_next;
    logic [DW-1:0] tx_data_reg, tx_data_next;
    logic          tx_send_reg, tx_send_next;
    logic          link_up_reg, link_up_next;
    logic          initiator_reg, initiator_next;
    logic          link_lost_reg, link_lost_next;
    logic          failed_reg, failed_next;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    logic          rx_rdy, rx_rdy_ack, rx_start, rx_start_ack;
    logic          can_send, wait_expired, retry_fail, loss_fire;
    logic [RW-1:0] retry_inc;
    logic [CW-1:0] loss_run;

    assign rx_rdy       = rx_valid && (rx_data == CODE_RDY);
    assign rx_rdy_ack   = rx_valid && (rx_data == CODE_RDY_ACK);
    assign rx_start     = rx_valid && (rx_data == CODE_START);
    assign rx_start_ack = rx_valid && (rx_data == CODE_START_ACK);
    // The extra tx_send_reg term keeps strobes at least one idle cycle apart.
    assign can_send     = !tx_busy && !tx_send_reg;
    assign wait_expired = (wait_reg >= WAIT_LAST);
    assign retry_inc    = (retry_reg == '1) ? retry_reg : retry_reg + RW'(1);
    assign retry_fail   = (MAX_RETRY != 0) && (retry_inc > RETRY_LIMIT);
    assign loss_fire    = !rx_valid && (loss_reg >= LOSS_LAST);
    assign loss_run     = rx_valid ? '0 : sat_inc(loss_reg);

    always_comb begin
        state_next     = state_reg;
        wait_next      = '0;
        hb_next        = '0;
        loss_next      = '0;
        retry_next     = retry_reg;
        tx_data_next   = tx_data_reg;
        tx_send_next   = 1'b0;
        initiator_next = initiator_reg;
        link_lost_next = 1'b0;

        case (state_reg)
            S_INVITE: if (can_send) begin
                tx_send_next = 1'b1; tx_data_next = CODE_RDY; state_next = S_INV_WAIT;
            end
            S_INV_WAIT: begin
                if (rx_rdy_ack)        state_next = S_STARTG;
                else if (rx_rdy)       state_next = S_INV_ACK;
                else if (wait_expired) begin
                    retry_next = retry_inc;
                    state_next = retry_fail ? S_FAILED : S_INVITE;
                end else               wait_next = sat_inc(wait_reg);
            end
            S_INV_ACK: if (can_send) begin
                tx_send_next = 1'b1; tx_data_next = CODE_RDY_ACK; state_next = S_INV_ACK_WAIT;
            end
            S_INV_ACK_WAIT: begin
                if (rx_start)          state_next = S_STARTG_ACK;
                else if (rx_rdy)       state_next = S_INV_ACK;
                else if (wait_expired) begin
                    retry_next = retry_inc;
                    state_next = retry_fail ? S_FAILED : S_INVITE;
                end else               wait_next = sat_inc(wait_reg);
            end
            S_STARTG: if (can_send) begin
                tx_send_next = 1'b1; tx_data_next = CODE_START; state_next = S_STARTG_WAIT;
            end
            S_STARTG_WAIT: begin
                if (rx_start_ack) begin
                    state_next = S_CONNECTED; initiator_next = 1'b1; retry_next = '0;
                end else if (wait_expired) begin
                    retry_next = retry_inc;
                    state_next = retry_fail ? S_FAILED : S_INVITE;
                end else wait_next = sat_inc(wait_reg);
            end
            S_STARTG_ACK: if (can_send) begin
                tx_send_next = 1'b1; tx_data_next = CODE_START_ACK;
                state_next = S_CONNECTED; initiator_next = 1'b0; retry_next = '0;
            end
            S_CONNECTED: begin
                loss_next = loss_run;
                hb_next   = sat_inc(hb_reg);
                if (loss_fire) begin
                    link_lost_next = 1'b1; state_next = S_INVITE;
                end else if (rx_rdy) begin
                    state_next = S_INV_ACK;
                end else if (hb_reg >= HB_LAST) begin
                    state_next = S_HB_SEND; hb_next = '0;
                end
            end
            S_HB_SEND: begin
                // Loss supervision continues while the heartbeat waits for the transmitter.
                loss_next = loss_run;
                if (loss_fire) begin
                    link_lost_next = 1'b1; state_next = S_INVITE;
                end else if (can_send) begin
                    tx_send_next = 1'b1; tx_data_next = CODE_HB; state_next = S_CONNECTED;
                end
            end
            S_FAILED: if (restart) begin
                state_next = S_INVITE; retry_next = '0;
            end
            default: state_next = S_INVITE;
        endcase

        link_up_next = (state_next == S_CONNECTED) || (state_next == S_HB_SEND);
        failed_next  = (state_next == S_FAILED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_INVITE;
            wait_reg      <= '0;
            hb_reg        <= '0;
            loss_reg      <= '0;
            retry_reg     <= '0;
            tx_data_reg   <= '0;
            tx_send_reg   <= 1'b0;
            link_up_reg   <= 1'b0;
            initiator_reg <= 1'b0;
            link_lost_reg <= 1'b0;
            failed_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_reg      <= wait_next;
            hb_reg        <= hb_next;
            loss_reg      <= loss_next;
            retry_reg     <= retry_next;
            tx_data_reg   <= tx_data_next;
            tx_send_reg   <= tx_send_next;
            link_up_reg   <= link_up_next;
            initiator_reg <= initiator_next;
            link_lost_reg <= link_lost_next;
            failed_reg    <= failed_next;
        end
    end

    assign tx_data   = tx_data_reg;
    assign tx_send   = tx_send_reg;
    assign link_up   = link_up_reg;
    assign initiator = initiator_reg;
    assign link_lost = link_lost_reg;
    assign failed    = failed_reg;

endmodule

// File: tb/tb_link_handshake.sv
// Randomized bench for link_handshake: peer behaviour is scripted per scenario and the expected
// send latencies, heartbeat times and loss time are computed from the protocol timing rules.
module tb_link_handshake;

    localparam int TO   = 20;
    localparam int MR   = 2;
    localparam int HB   = 8;
    localparam int LOSS = 30;
    localparam logic [7:0] C_RDY = 8'h90, C_RDY_ACK = 8'h91, C_START = 8'h92,
                           C_START_ACK = 8'h93, C_HB = 8'h94;

    logic       clk = 1'b0;
    logic       reset, restart, rx_valid, tx_busy;
    logic [7:0] rx_data, tx_data;
    logic       tx_send, link_up, initiator, link_lost, failed;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic busy_q = 1'b0;
    logic prev_send = 1'b0;

    link_handshake #(
        .DW(8), .TIMEOUT(TO), .MAX_RETRY(MR), .HB_PERIOD(HB), .LOSS_TIMEOUT(LOSS)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_send(tx_send), .link_up(link_up),
        .initiator(initiator), .link_lost(link_lost), .failed(failed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        busy_q <= tx_busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("[%0d] %s ok got=%0h", cyc, tag, got);
        end else begin
            $display("[%0d] FAIL %s got=%0h exp=%0h", cyc, tag, got, exp);
        end
    endtask

    // Every strobe: never back-to-back and never issued while the transmitter was busy.
    always @(negedge clk) begin
        if (!reset && tx_send) begin
            chk("tx_gap", prev_send, 0);
            chk("tx_busy_ok", busy_q, 0);
        end
        prev_send <= tx_send;
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit busy);
        rx_valid = 1'b0; restart = 1'b0; tx_busy = busy; reset = 1'b1;
        step; step;
        reset = 1'b0;
    endtask

    task automatic idle(input int n, input bit junk);
        for (int i = 0; i < n; i++) begin
            rx_valid = junk && ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom_range(0, 'h8f));
            step;
            rx_valid = 1'b0;
        end
    endtask

    task automatic inject(input logic [7:0] code);
        rx_valid = 1'b1; rx_data = code;
        step;
        rx_valid = 1'b0;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] code, input int dly_exp);
        int  n;
        bit  got;
        n = 0; got = 0;
        while (!got && n < 200) begin
            step; n++;
            if (tx_send) got = 1;
        end
        chk({tag, "_lat"}, got ? n : -1, dly_exp);
        chk({tag, "_code"}, tx_data, code);
    endtask

    task automatic hb_run(input int e, input int p);
        int c0, r, lost_cyc, drops, n;
        int tq[$];
        int dq[$];
        int exp_t[$];
        do_reset(0);
        expect_tx("h_rdy", C_RDY, 1);
        inject(C_RDY_ACK);
        expect_tx("h_start", C_START, 1);
        inject(C_START_ACK);
        chk("h_link_up", link_up, 1);
        c0 = cyc; r = c0; lost_cyc = -1; drops = 0;
        for (int i = 0; i < p; i++) begin
            if ((i % e) == e - 1) begin
                rx_valid = 1'b1; rx_data = 8'($urandom_range(0, 'h8f)); r = cyc + 1;
            end
            step;
            rx_valid = 1'b0;
            if (tx_send) begin tq.push_back(cyc); dq.push_back(int'(tx_data)); end
            if (link_up !== 1'b1) drops++;
        end
        n = 0;
        while (lost_cyc < 0 && n < 3 * LOSS) begin
            step; n++;
            if (tx_send) begin tq.push_back(cyc); dq.push_back(int'(tx_data)); end
            if (link_lost) lost_cyc = cyc;
            else if (link_up !== 1'b1) drops++;
        end
        chk("h_lost_time", lost_cyc, r + LOSS);
        chk("h_lost_link_down", link_up, 0);
        chk("h_link_held", drops, 0);
        for (int t = c0 + HB + 1; t < r + LOSS; t += HB + 1) exp_t.push_back(t);
        chk("h_hb_count", tq.size(), exp_t.size());
        for (int k = 0; k < tq.size() && k < exp_t.size(); k++) begin
            chk("h_hb_time", tq[k], exp_t[k]);
            chk("h_hb_code", dq[k], C_HB);
        end
        step;
        chk("h_relink_send", tx_send, 1);
        chk("h_relink_code", tx_data, C_RDY);
        chk("h_lost_pulse", link_lost, 0);
    endtask

    initial begin
        int d, b, cnt;
        reset = 1'b1; restart = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_busy = 1'b0;
        step; step;
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_link_up", link_up, 0);
        chk("rst_initiator", initiator, 0);
        chk("rst_link_lost", link_lost, 0);
        chk("rst_failed", failed, 0);
        reset = 1'b0;
        expect_tx("boot_rdy", C_RDY, 1);

        // Initiator role, random reply delays (first pass exactly on the INV_WAIT timeout cycle)
        for (int it = 0; it < 4; it++) begin
            do_reset(0);
            expect_tx("i_rdy", C_RDY, 1);
            d = (it == 0) ? TO - 1 : $urandom_range(0, TO - 1);
            idle(d, 1);
            b = $urandom_range(0, 4);
            tx_busy = (b != 0);
            inject(C_RDY_ACK);
            repeat (b) step;
            tx_busy = 1'b0;
            expect_tx("i_start", C_START, 1);
            idle($urandom_range(0, TO - 1), 1);
            inject(C_START_ACK);
            chk("i_link_up", link_up, 1);
            chk("i_initiator", initiator, 1);
            chk("i_failed", failed, 0);
        end

        // Responder role, optional peer resend, then peer reboot while connected
        for (int it = 0; it < 4; it++) begin
            do_reset(0);
            expect_tx("r_rdy", C_RDY, 1);
            idle($urandom_range(0, TO - 1), 1);
            inject(C_RDY);
            expect_tx("r_rdy_ack", C_RDY_ACK, 1);
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(0, TO - 1), 1);
                inject(C_RDY);
                expect_tx("r_resend_ack", C_RDY_ACK, 1);
            end
            idle($urandom_range(0, TO - 1), 1);
            inject(C_START);
            expect_tx("r_start_ack", C_START_ACK, 1);
            chk("r_link_up", link_up, 1);
            chk("r_initiator", initiator, 0);
            idle($urandom_range(0, 5), 1);
            inject(C_RDY);
            chk("reboot_link_up", link_up, 0);
            chk("reboot_lost", link_lost, 0);
            expect_tx("reboot_ack", C_RDY_ACK, 1);
        end

        // Retry exhaustion, silence in FAILED, restart, restart ignored outside FAILED
        do_reset(0);
        expect_tx("f_rdy1", C_RDY, 1);
        expect_tx("f_rdy2", C_RDY, TO + 1);
        expect_tx("f_rdy3", C_RDY, TO + 1);
        repeat (TO - 1) step;
        chk("f_not_yet", failed, 0);
        step;
        chk("f_failed", failed, 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom_range('h90, 'h94));
            step;
            rx_valid = 1'b0;
            if (tx_send) cnt++;
        end
        chk("f_quiet", cnt, 0);
        chk("f_still_failed", failed, 1);
        restart = 1'b1; step; restart = 1'b0;
        chk("f_cleared", failed, 0);
        expect_tx("f_restart_rdy", C_RDY, 1);
        repeat (5) step;
        restart = 1'b1; step; restart = 1'b0;
        expect_tx("f_ignored_restart", C_RDY, TO + 1 - 6);
        expect_tx("f_rdy_b3", C_RDY, TO + 1);
        repeat (TO) step;
        chk("f_failed2", failed, 1);

        // tx_busy held in INVITE
        for (int it = 0; it < 3; it++) begin
            do_reset(1);
            b = (it == 0) ? 5 : $urandom_range(1, 10);
            cnt = 0;
            repeat (b) begin step; if (tx_send) cnt++; end
            chk("b_hold", cnt, 0);
            tx_busy = 1'b0;
            step;
            chk("b_strobe", tx_send, 1);
            chk("b_code", tx_data, C_RDY);
            step;
            chk("b_single", tx_send, 0);
        end

        // Heartbeat and loss
        hb_run(10, 60);
        hb_run($urandom_range(1, LOSS - 1), $urandom_range(40, 80));

        // START_ACK on the STARTG_WAIT timeout cycle with two timeouts already counted
        do_reset(0);
        expect_tx("x_rdy1", C_RDY, 1);
        expect_tx("x_rdy2", C_RDY, TO + 1);
        expect_tx("x_rdy3", C_RDY, TO + 1);
        idle($urandom_range(0, TO - 1), 1);
        inject(C_RDY_ACK);
        expect_tx("x_start", C_START, 1);
        idle(TO - 1, 1);
        inject(C_START_ACK);
        chk("x_link_up", link_up, 1);
        chk("x_failed", failed, 0);
        chk("x_initiator", initiator, 1);
        repeat (3) step;
        chk("x_link_stays", link_up, 1);

        // Reply one cycle too late: timeout already resent RDY
        do_reset(0);
        expect_tx("late_rdy", C_RDY, 1);
        idle(TO, 1);
        inject(C_RDY_ACK);
        chk("late_send", tx_send, 1);
        chk("late_code", tx_data, C_RDY);
        chk("late_link", link_up, 0);

        // Async reset while connected with a strobe pending
        do_reset(0);
        expect_tx("a_rdy", C_RDY, 1);
        inject(C_RDY);
        expect_tx("a_rdy_ack", C_RDY_ACK, 1);
        inject(C_START);
        expect_tx("a_start_ack", C_START_ACK, 1);
        chk("a_link_pre", link_up, 1);
        #1 reset = 1'b1;
        #1;
        chk("a_async_link", link_up, 0);
        chk("a_async_send", tx_send, 0);
        step;
        reset = 1'b0;
        expect_tx("a_reboot_rdy", C_RDY, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
